// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants for the load/store unit and its fault checker.
//   - RV32I load/store funct3 encodings
//   - fault codes reported on resp_fault
//   - FSM state encoding for load_store_unit
package lsu_pkg;

   typedef logic [1:0] fault_t;
   typedef logic [1:0] lsu_state_t;

   // funct3 encodings (loads and stores share the size field)
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   // Fault codes
   localparam fault_t FLT_NONE     = 2'b00;
   localparam fault_t FLT_ILLEGAL  = 2'b01;
   localparam fault_t FLT_MISALIGN = 2'b10;
   localparam fault_t FLT_RANGE    = 2'b11;

   // FSM states
   localparam lsu_state_t ST_IDLE   = 2'd0;
   localparam lsu_state_t ST_ACCESS = 2'd1;
   localparam lsu_state_t ST_RESP   = 2'd2;

endpackage

// File: rtl/lsu_fault_check.sv
// lsu_fault_check: combinational legality/alignment/range check for one access.
// Ports:
//   addr      in  32  effective byte address
//   funct3    in  3   RV32I load/store funct3
//   is_store  in  1   1 = store, 0 = load
//   fault     out 2   FLT_NONE / FLT_ILLEGAL / FLT_MISALIGN / FLT_RANGE
// Priority: illegal > misaligned > out of range.
module lsu_fault_check
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic [31:0] addr,
   input  logic [2:0]  funct3,
   input  logic        is_store,
   output fault_t      fault
);

   localparam logic [31:0] MemLimit = 32'(MEM_BYTES);

   logic illegal;
   logic misalign;
   logic out_of_range;

   always_comb begin
      if (is_store) begin
         illegal = !(funct3 inside {SB, SH, SW});
      end else begin
         illegal = funct3 inside {3'b011, 3'b110, 3'b111};
      end

      misalign = ((funct3 == LH || funct3 == LHU) && addr[0]) ||
                 ((funct3 == LW) && (addr[1:0] != 2'b00));

      out_of_range = (addr >= MemLimit);

      if (illegal) begin
         fault = FLT_ILLEGAL;
      end else if (misalign) begin
         fault = FLT_MISALIGN;
      end else if (out_of_range) begin
         fault = FLT_RANGE;
      end else begin
         fault = FLT_NONE;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: request/response front end for the data memory.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            request handshake from execute
//   req_is_store, req_funct3       access kind and size/sign
//   req_base, req_offset           effective address = base + offset (mod 2^32)
//   req_wdata, req_rd              store data, load destination
//   resp_valid/resp_ready          response handshake to writeback
//   resp_rdata, resp_rd            load result (0 for stores/faults), echoed rd
//   resp_is_load, resp_fault       echoed kind, fault code
//   mem_read, mem_write            data-memory enables (ACCESS only)
//   mem_address, mem_write_data    registered address / store data
//   mem_funct3, mem_read_data      registered size/sign, combinational read result
//   fault_count                    saturating count of faulted requests
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned FCNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_store,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_base,
   input  logic [31:0]       req_offset,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic [4:0]        resp_rd,
   output logic              resp_is_load,
   output logic [1:0]        resp_fault,
   output logic              mem_read,
   output logic              mem_write,
   output logic [31:0]       mem_address,
   output logic [31:0]       mem_write_data,
   output logic [2:0]        mem_funct3,
   input  logic [31:0]       mem_read_data,
   output logic [FCNT_W-1:0] fault_count
);

   lsu_state_t        state_q, state_d;
   logic [31:0]       addr_q, wdata_q, rdata_q;
   logic [2:0]        funct3_q;
   logic [4:0]        rd_q;
   logic              is_load_q;
   fault_t            fault_q;
   logic [FCNT_W-1:0] fault_count_q;

   logic [31:0] eff_addr;
   fault_t      req_fault;
   logic        accept;

   assign eff_addr = req_base + req_offset;
   assign accept   = req_valid && (state_q == ST_IDLE);

   lsu_fault_check #(
      .MEM_BYTES (MEM_BYTES)
   ) u_fault_check (
      .addr     (eff_addr),
      .funct3   (req_funct3),
      .is_store (req_is_store),
      .fault    (req_fault)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = (req_fault == FLT_NONE) ? ST_ACCESS : ST_RESP;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         funct3_q      <= '0;
         rd_q          <= '0;
         is_load_q     <= 1'b0;
         fault_q       <= FLT_NONE;
         fault_count_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q    <= eff_addr;
            wdata_q   <= req_wdata;
            funct3_q  <= req_funct3;
            rd_q      <= req_rd;
            is_load_q <= ~req_is_store;
            fault_q   <= req_fault;
            rdata_q   <= '0;
            if ((req_fault != FLT_NONE) && (fault_count_q != '1)) begin
               fault_count_q <= fault_count_q + FCNT_W'(1);
            end
         end
         if ((state_q == ST_ACCESS) && is_load_q) begin
            rdata_q <= mem_read_data;
         end
      end
   end

   // Enables decode straight from state so an async reset drops them at once.
   assign mem_read       = (state_q == ST_ACCESS) && is_load_q;
   assign mem_write      = (state_q == ST_ACCESS) && !is_load_q;
   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_funct3     = funct3_q;

   assign req_ready    = (state_q == ST_IDLE);
   assign resp_valid   = (state_q == ST_RESP);
   assign resp_rdata   = rdata_q;
   assign resp_rd      = rd_q;
   assign resp_is_load = is_load_q;
   assign resp_fault   = fault_q;
   assign fault_count  = fault_count_q;

endmodule
